// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART blocks (receiver today, a
// matching transmitter later).
//   - PARITY_NONE / PARITY_ODD / PARITY_EVEN : parity mode encodings
//   - uart_state_e                           : receiver FSM states
//   - baud_max()                             : clock cycles per bit
//   - maj3()                                 : 2-of-3 majority vote
//   - parity_fail()                          : parity check for a given mode
// Optional build macro used by consumers: UART_RX_MAJORITY_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Number of system clock cycles spanned by one bit on the line.
    function automatic int baud_max(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ones_xor is the XOR of the data word and the received parity bit.
    function automatic logic parity_fail(input logic ones_xor, input int mode);
        logic fail_s;
        case (mode)
            PARITY_ODD:  fail_s = ~ones_xor;
            PARITY_EVEN: fail_s = ones_xor;
            default:     fail_s = 1'b0;
        endcase
        return fail_s;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter shared by the UART receiver and a future transmitter.
// Counts 0..CNT_MAX-1 and wraps while enabled; held at 0 while disabled.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   en    : count enable (frame in progress)
//   clr   : restart the bit period at 0 (start of a frame)
//   mid   : strobe at count MID_CNT (sampling point)
//   done  : strobe at count CNT_MAX-1 (bit boundary)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CNT_MAX = 16,
    parameter int MID_CNT = CNT_MAX / 2 - 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic mid,
    output logic done
);

    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [CW-1:0] cnt_r;

    // Bit-period counter with clear and wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || !en) begin
            cnt_r <= '0;
        end else if (cnt_r == CW'(CNT_MAX - 1)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign mid  = en && (cnt_r == CW'(MID_CNT));
    assign done = en && (cnt_r == CW'(CNT_MAX - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional odd or
// even parity, one or two stop bits. Rejects false starts, reports parity and
// framing errors, and emits one-cycle result pulses.
//   sys_clk    : system clock
//   sys_rst_n  : synchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   po_data    : received word, held until the next po_flag
//   po_flag    : one-cycle pulse, po_data / parity_err / frame_err valid
//   parity_err : parity mismatch on the flagged frame
//   frame_err  : a stop bit was sampled low on the flagged frame
//   busy       : frame reception in progress
// Build option UART_RX_MAJORITY_EN: each bit decision becomes the 2-of-3 vote
// of the synchronised line one cycle before, at, and one cycle after the
// mid-bit point, which moves every decision (and po_flag) one cycle later.
// -----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UART_BPS    = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_CNT_MAX = baud_max(CLK_FREQ, UART_BPS);
`ifdef UART_RX_MAJORITY_EN
    localparam int MID_CNT = BAUD_CNT_MAX / 2;
`else
    localparam int MID_CNT = BAUD_CNT_MAX / 2 - 1;
`endif

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 dly_r;
`ifdef UART_RX_MAJORITY_EN
    logic                 dly2_r;
`endif
    logic                 sample_s;
    logic                 fall_s;
    logic                 mid_s;
    logic                 done_s;
    uart_state_e          state_r;
    logic [3:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_err_r;
    logic                 frm_err_r;

    // Two-flop synchroniser plus delay flop(s) for edge detect and voting.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            dly_r   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            dly2_r  <= 1'b1;
`endif
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
`ifdef UART_RX_MAJORITY_EN
            dly2_r  <= dly_r;
`endif
        end
    end

    // Line value used at each bit decision.
    always_comb begin
`ifdef UART_RX_MAJORITY_EN
        sample_s = maj3(sync2_r, dly_r, dly2_r);
`else
        sample_s = sync2_r;
`endif
    end

    assign fall_s = !sync2_r && dly_r;
    assign busy   = (state_r != ST_IDLE);

    uart_baud_gen #(
        .CNT_MAX (BAUD_CNT_MAX),
        .MID_CNT (MID_CNT)
    ) u_baud (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (state_r != ST_IDLE),
        .clr   ((state_r == ST_IDLE) && fall_s),
        .mid   (mid_s),
        .done  (done_s)
    );

    // Frame FSM, data shift register, error accumulation and result registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            bit_idx_r  <= 4'd0;
            shift_r    <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            po_data    <= '0;
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            po_flag <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r   <= ST_START;
                        bit_idx_r <= 4'd0;
                        par_err_r <= 1'b0;
                        frm_err_r <= 1'b0;
                    end
                end
                ST_START: begin
                    // Line back high mid start bit: glitch, not a frame.
                    if (mid_s && sample_s) begin
                        state_r <= ST_IDLE;
                    end else if (done_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_r <= {sample_s, shift_r[DATA_BITS-1:1]};
                    end
                    if (done_s) begin
                        if (bit_idx_r == 4'(DATA_BITS - 1)) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid_s) begin
                        par_err_r <= parity_fail((^shift_r) ^ sample_s, PARITY_MODE);
                    end
                    if (done_s) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Finish at the last stop mid-sample so a following start
                    // bit with no idle gap is still caught by the edge detect.
                    if (mid_s) begin
                        if (bit_idx_r == 4'(STOP_BITS - 1)) begin
                            po_data    <= shift_r;
                            parity_err <= par_err_r;
                            frame_err  <= frm_err_r | ~sample_s;
                            po_flag    <= 1'b1;
                            bit_idx_r  <= 4'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            frm_err_r <= frm_err_r | ~sample_s;
                        end
                    end else if (done_s) begin
                        bit_idx_r <= bit_idx_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed bench for uart_rx_cfg at 1.6 MHz / 100 kbaud (16 clocks per bit).
// Three instances: 8N1 (line 0), 8E1 (line 1), 7O2 (line 2).
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

    logic       clk;
    logic       rst_n;
    logic [2:0] rx_v;
    int         cyc;
    int         n_vec;
    int         n_err;

    logic [7:0] data_a;
    logic       flag_a, perr_a, ferr_a, busy_a;
    logic [7:0] data_b;
    logic       flag_b, perr_b, ferr_b, busy_b;
    logic [6:0] data_c;
    logic       flag_c, perr_c, ferr_c, busy_c;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    rec_t q_c[$];

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[0]), .po_data(data_a),
        .po_flag(flag_a), .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[1]), .po_data(data_b),
        .po_flag(flag_b), .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .DATA_BITS(7),
                  .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[2]), .po_data(data_c),
        .po_flag(flag_c), .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (flag_a === 1'b1) q_a.push_back('{{1'b0, data_a}, perr_a, ferr_a, cyc});
        if (flag_b === 1'b1) q_b.push_back('{{1'b0, data_b}, perr_b, ferr_b, cyc});
        if (flag_c === 1'b1) q_c.push_back('{{2'b00, data_c}, perr_c, ferr_c, cyc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n bits LSB first, 16 clocks each, then leave the line idle high.
    task automatic drive_bits(input int line, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_v[line] = bits[i];
            tick(16);
        end
        rx_v[line] = 1'b1;
    endtask

    function automatic logic [31:0] f8n1(input logic [7:0] d);
        return {22'd0, 1'b1, d, 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rx_v  = 3'b111;
        tick(3);
        n_vec++; if ({data_a, flag_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
            n_err++; $display("FAIL reset_8n1: got %h, expected 000", {data_a, flag_a, perr_a, ferr_a, busy_a}); end
        n_vec++; if ({data_b, flag_b, perr_b, ferr_b, busy_b} !== 12'h000) begin
            n_err++; $display("FAIL reset_8e1: got %h, expected 000", {data_b, flag_b, perr_b, ferr_b, busy_b}); end
        n_vec++; if ({data_c, flag_c, perr_c, ferr_c, busy_c} !== 11'h000) begin
            n_err++; $display("FAIL reset_7o2: got %h, expected 000", {data_c, flag_c, perr_c, ferr_c, busy_c}); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_8n1_basic();
        int t0;
        q_a.delete();
        t0 = cyc;
        drive_bits(0, f8n1(8'h55), 10);
        tick(20);
        n_vec++; if (q_a.size() != 1) begin
            n_err++; $display("FAIL basic_count: got %0d flags, expected 1", q_a.size()); end
        if (q_a.size() >= 1) begin
            n_vec++; if (q_a[0].data !== 9'h055) begin
                n_err++; $display("FAIL basic_data: got %h, expected 055", q_a[0].data); end
            n_vec++; if ({q_a[0].perr, q_a[0].ferr} !== 2'b00) begin
                n_err++; $display("FAIL basic_errs: got %b, expected 00", {q_a[0].perr, q_a[0].ferr}); end
            n_vec++; if (q_a[0].cyc - t0 != 155) begin
                n_err++; $display("FAIL basic_latency: got %0d, expected 155", q_a[0].cyc - t0); end
        end
    endtask

    task automatic test_even_parity();
        q_b.delete();
        drive_bits(1, {21'd0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
        tick(20);
        drive_bits(1, {21'd0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
        tick(20);
        n_vec++; if (q_b.size() != 2) begin
            n_err++; $display("FAIL even_count: got %0d flags, expected 2", q_b.size()); end
        if (q_b.size() >= 2) begin
            n_vec++; if ({q_b[0].data, q_b[0].perr, q_b[0].ferr} !== {9'h0A3, 2'b00}) begin
                n_err++; $display("FAIL even_good: got %h, expected %h", {q_b[0].data, q_b[0].perr, q_b[0].ferr}, {9'h0A3, 2'b00}); end
            n_vec++; if ({q_b[1].data, q_b[1].perr, q_b[1].ferr} !== {9'h0A3, 2'b10}) begin
                n_err++; $display("FAIL even_bad: got %h, expected %h", {q_b[1].data, q_b[1].perr, q_b[1].ferr}, {9'h0A3, 2'b10}); end
        end
    endtask

    task automatic test_odd_two_stop();
        q_c.delete();
        // 0x41 has two ones: odd parity bit 1; second stop bit driven low.
        drive_bits(2, {21'd0, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
        tick(20);
        n_vec++; if (q_c.size() != 1) begin
            n_err++; $display("FAIL odd_count: got %0d flags, expected 1", q_c.size()); end
        if (q_c.size() >= 1) begin
            n_vec++; if (q_c[0].data !== 9'h041) begin
                n_err++; $display("FAIL odd_data: got %h, expected 041", q_c[0].data); end
            n_vec++; if ({q_c[0].perr, q_c[0].ferr} !== 2'b01) begin
                n_err++; $display("FAIL odd_errs: got %b, expected 01", {q_c[0].perr, q_c[0].ferr}); end
        end
    endtask

    task automatic test_false_start();
        q_a.delete();
        rx_v[0] = 1'b0;
        tick(5);
        rx_v[0] = 1'b1;
        n_vec++; if (busy_a !== 1'b1) begin
            n_err++; $display("FAIL glitch_busy_hi: got %b, expected 1", busy_a); end
        tick(11);
        n_vec++; if (busy_a !== 1'b0) begin
            n_err++; $display("FAIL glitch_busy_lo: got %b, expected 0", busy_a); end
        n_vec++; if (q_a.size() != 0) begin
            n_err++; $display("FAIL glitch_flag: got %0d flags, expected 0", q_a.size()); end
        drive_bits(0, f8n1(8'h3C), 10);
        tick(20);
        n_vec++; if (q_a.size() != 1) begin
            n_err++; $display("FAIL after_glitch_count: got %0d flags, expected 1", q_a.size()); end
        if (q_a.size() >= 1) begin
            n_vec++; if ({q_a[0].data, q_a[0].perr, q_a[0].ferr} !== {9'h03C, 2'b00}) begin
                n_err++; $display("FAIL after_glitch_data: got %h, expected %h", {q_a[0].data, q_a[0].perr, q_a[0].ferr}, {9'h03C, 2'b00}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h12;
        exp_d[1] = 8'h34;
        exp_d[2] = 8'hFF;
        q_a.delete();
        for (int i = 0; i < 3; i++) drive_bits(0, f8n1(exp_d[i]), 10);
        tick(20);
        n_vec++; if (q_a.size() != 3) begin
            n_err++; $display("FAIL b2b_count: got %0d flags, expected 3", q_a.size()); end
        if (q_a.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++; if ({q_a[i].data, q_a[i].perr, q_a[i].ferr} !== {1'b0, exp_d[i], 2'b00}) begin
                    n_err++; $display("FAIL b2b_frame%0d: got %h, expected %h", i, {q_a[i].data, q_a[i].perr, q_a[i].ferr}, {1'b0, exp_d[i], 2'b00}); end
            end
            n_vec++; if (q_a[1].cyc - q_a[0].cyc != 160) begin
                n_err++; $display("FAIL b2b_spacing: got %0d, expected 160", q_a[1].cyc - q_a[0].cyc); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] bits;
        bits = f8n1(8'h99);
        q_a.delete();
        for (int i = 0; i < 5; i++) begin
            rx_v[0] = bits[i];
            tick(16);
        end
        n_vec++; if (busy_a !== 1'b1) begin
            n_err++; $display("FAIL mid_frame_busy: got %b, expected 1", busy_a); end
        rst_n   = 1'b0;
        rx_v[0] = 1'b1;
        tick(1);
        n_vec++; if ({data_a, flag_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
            n_err++; $display("FAIL mid_reset_outs: got %h, expected 000", {data_a, flag_a, perr_a, ferr_a, busy_a}); end
        rst_n = 1'b1;
        tick(40);
        n_vec++; if (q_a.size() != 0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_quiet: got %0d flags busy %b, expected 0 flags busy 0", q_a.size(), busy_a); end
        drive_bits(0, f8n1(8'h66), 10);
        tick(20);
        n_vec++; if (q_a.size() != 1) begin
            n_err++; $display("FAIL post_reset_count: got %0d flags, expected 1", q_a.size()); end
        if (q_a.size() >= 1) begin
            n_vec++; if ({q_a[0].data, q_a[0].perr, q_a[0].ferr} !== {9'h066, 2'b00}) begin
                n_err++; $display("FAIL post_reset_data: got %h, expected %h", {q_a[0].data, q_a[0].perr, q_a[0].ferr}, {9'h066, 2'b00}); end
        end
    endtask

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_8n1_basic();
        test_even_parity();
        test_odd_two_stop();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds the following over that block:
- configurable data width, parity and stop-bit count
- false-start rejection
- parity and framing error reporting
- busy indication

Sits between the board rx pin and the byte-consuming logic (loopback, command parser). Emits one-cycle result pulses.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 9600, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS, must be >= 8
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  reset, synchronous, active-low
rx  input  1  asynchronous serial line, idle high
po_data  output  DATA_BITS  received word, LSB = first data bit
po_flag  output  1  one-cycle pulse: po_data, parity_err and frame_err valid
parity_err  output  1  parity mismatch on the frame flagged by po_flag
frame_err  output  1  a stop bit sampled low on the frame flagged by po_flag
busy  output  1  high while a frame is being received (any state except IDLE)

Behaviour:
- Reset: sys_rst_n low at a clock edge clears everything.
  - Sync/edge flops load 1; FSM goes to IDLE; counters go to 0.
  - po_data = 0, po_flag = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Reset mid-frame abandons the frame with no po_flag.
- Input path: two-flop synchroniser plus one delay flop. A falling edge is sync = 0 and delayed = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a falling edge. baud_cnt = 0 and bit_idx = 0 in the first START cycle.
- Baud counter:
  - Counts 0..BAUD_CNT_MAX-1 and wraps while not in IDLE.
  - Mid-bit sample strobe at baud_cnt == BAUD_CNT_MAX/2 - 1.
  - Bit advance at baud_cnt == BAUD_CNT_MAX-1.
- START: at the mid sample, if the line is high it is a false start. Go to IDLE, no po_flag, no error. Otherwise continue to DATA at the bit advance.
- DATA:
  - Sample DATA_BITS bits LSB-first into a shift register.
  - Go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample one bit.
  - Odd mode: error if XOR of (data, parity bit) == 0.
  - Even mode: error if that XOR == 1.
- STOP:
  - Sample STOP_BITS bits; any low sample sets the frame error.
  - At the mid sample of the last stop bit, register the outputs and go to IDLE that same cycle. The rest of the stop bit is not waited out, so back-to-back frames with no idle gap are received.
- Output timing:
  - po_flag is high exactly one cycle, the cycle after the last stop mid-sample edge.
  - po_data, parity_err and frame_err update in that same cycle and hold until the next po_flag.
- Latency: the falling edge reaches the sync output 2 cycles after the rx pin edge. po_flag follows at (frame_bits-1)*BAUD_CNT_MAX + BAUD_CNT_MAX/2 + 1 cycles after that.
- Break: line held low through the frame gives frame_err = 1 and po_data = 0. No new start is recognised until rx has returned high, because a falling edge is required.
- parity_err is always 0 when PARITY_MODE = 0.
- Widths: baud_cnt is $clog2(BAUD_CNT_MAX) bits; bit_idx is 4 bits.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each sample is the 2-of-3 majority of sync values at mid-1, mid and mid+1. The start-bit check uses the same vote. Latency grows by one cycle.
- Undefined: single sample at the mid strobe; timing exactly as stated above.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN localparams
  - FSM state enum
  - baud_max(clk, bps) constant function
- One sub-module, uart_baud_gen. Contains the counter with enable, clear-on-start, mid strobe and end strobe. It is reusable by a future uart_tx_cfg.

Test Plan:
Bench clock 1_600_000 Hz, UART_BPS 100_000, so BAUD_CNT_MAX = 16.
- 8N1, send 0x55 -> po_flag once, po_data = 0x55, both errors 0. Flag 2 + 9*16 + 8 + 1 cycles after the start edge (majority-vote macro undefined).
- 8E1, send 0xA3 with parity bit 0 -> po_data = 0xA3, parity_err = 0. Resend with parity bit 1 -> parity_err = 1, po_data = 0xA3.
- 7O2, send 0x41 with second stop bit driven low -> frame_err = 1, po_data = 0x41, parity_err = 0.
- 8N1, rx low glitch of 5 cycles -> no po_flag; busy returns to 0 within 16 cycles. Then a valid 0x3C -> po_data = 0x3C.
- 8N1, frames 0x12, 0x34, 0xFF back-to-back with no idle gap -> three po_flag pulses, in that order, no errors.
- 8N1, assert sys_rst_n low mid-DATA of 0x99 -> all outputs 0 next cycle, no po_flag. Then 0x66 after release -> po_data = 0x66.
